jbr_unit: RTL and testbench
===========================

Name: jbr_unit

Overview:
- Execute-stage branch resolution unit; producer of the 33-bit jump/branch bus {taken, target} consumed by the fetch-stage PC register.
- Registers one instruction from ID and evaluates LoongArch branch conditions and targets.
- Holds the redirect until fetch accepts it, then pulses a cancel to kill wrong-path instructions in IF/ID.
- Non-branch instructions pass through as a normal pipeline stage.

Parameters:
- RegW, 32, datapath/address width (`RegW in common.vh).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- id_to_ex_valid_i  in  1  ID holds a valid instruction.
- ex_allow_in_o  out  1  EX can accept from ID this cycle.
- id_br_op_i  in  4  branch opcode (see Behaviour).
- id_pc_i  in  RegW  instruction PC.
- id_src1_i  in  RegW  rj value.
- id_src2_i  in  RegW  rd value (compare operand).
- id_offs_i  in  RegW  offset, already sign-extended and shifted.
- if_allow_nxt_pc_i  in  1  fetch loads next_pc at this edge.
- jbr_bus_o  out  RegW+1  {taken, target}.
- ex_cancel_o  out  1  redirect accepted this cycle; IF/ID drop contents.
- ex_to_mem_valid_o  out  1  valid to MEM.
- mem_allow_in_i  in  1  MEM accepts.
- ex_pc_o  out  RegW  registered PC.
- ex_link_o  out  RegW  pc+4 for BL/JIRL, else 0.
- ex_adef_o  out  1  misaligned-target exception (optional feature).

Behaviour:
- Opcodes: 0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 B, 8 BL, 9 JIRL. Codes 10-15 are treated as NONE.
- Conditions:
  - BEQ: src1==src2. BNE: !=.
  - BLT/BGE: signed < and >=.
  - BLTU/BGEU: unsigned < and >=.
  - B/BL/JIRL: always taken.
- Target: pc+offs, except JIRL = src1+offs. All adds are modulo 2^RegW.
- Stage register:
  - Loads when ex_allow_in_o and id_to_ex_valid_i.
  - ex_allow_in_o = !ex_valid | (ready_go & mem_allow_in_i).
  - ex_to_mem_valid_o = ex_valid & ready_go.
- FSM states: IDLE, REDIRECT, DONE.
- taken_raw = ex_valid & cond & state==IDLE.
- jbr_bus_o[RegW] = taken_raw | state==REDIRECT. Target is combinational in IDLE and comes from target_q in REDIRECT. Target is 0 when not taken.
- accept = jbr_bus_o[RegW] & if_allow_nxt_pc_i. ex_cancel_o = accept, a single-cycle pulse.
- ready_go = !(jbr_bus_o[RegW] & !if_allow_nxt_pc_i). A branch never leaves EX before its redirect is accepted.
- Transitions:
  - IDLE: taken_raw & !accept → REDIRECT, latching target_q.
  - IDLE: accept & !leave → DONE.
  - IDLE: accept & leave → IDLE.
  - REDIRECT: accept → DONE, or IDLE if leaving the same cycle.
  - DONE: → IDLE when the instruction leaves.
  - leave = ex_to_mem_valid_o & mem_allow_in_i.
- Exactly one taken assertion-run and one cancel pulse per branch, regardless of MEM stall length.
- Simultaneous events:
  - On a cycle with ex_cancel_o, an instruction offered by ID is wrong-path. It is not loaded; ex_valid goes 0 if the branch leaves.
  - A not-taken branch behaves as NONE: no bus assertion, no cancel.
- Reset (async, any state including mid-REDIRECT): ex_valid=0, state=IDLE, target_q=0, all outputs 0, ex_allow_in_o=1 after reset.

Optional Feature:
- JBR_ALIGN_CHECK_EN defined:
  - A taken branch with target[1:0]!=0 does not assert the bus and does not cancel.
  - ex_adef_o=1 travels with the instruction to MEM; the FSM stays IDLE.
- Undefined: no check, target is passed unmodified, ex_adef_o tied 0.

Decomposition:
- Add to common.vh:
  - `RegW.
  - BR_OP_* opcode constants.
  - JBR_ST_IDLE/REDIRECT/DONE encodings.
  - `JBR_BUS_W = RegW+1.
- One combinational sub-module, jbr_cond: inputs op/pc/src1/src2/offs; outputs cond, target, link.

Test Plan:
- BEQ, pc=0x1c000100, src1=src2=5, offs=0x40, if_allow=1 → bus={1,0x1c000140} for one cycle, ex_cancel_o pulse, ID instruction dropped same cycle.
- BNE, src1=src2=7 → bus taken=0, no cancel, instruction reaches MEM next cycle.
- BLT, src1=0xFFFFFFFF, src2=1 → taken. BLTU with the same operands → not taken.
- JIRL, src1=0x1c001000, offs=8, pc=0x1c000200, if_allow low 3 cycles → bus held {1,0x1c001008} 3 cycles, ex_allow_in_o=0; cancel on the 4th; ex_link_o=0x1c000204.
- BL taken, accepted, mem_allow_in=0 for 4 cycles → state DONE, bus deasserted after accept, no second cancel; leaves on release.
- rst_n_i low while in REDIRECT → outputs 0 immediately (async), state IDLE. With JBR_ALIGN_CHECK_EN, JIRL target 0x1c001002 → no redirect, ex_adef_o=1.

Source files
------------

// File: rtl/jbr_unit_pkg.sv
// Shared widths, opcodes and FSM encodings for the EX-stage jump/branch unit.
// Optional feature macro: JBR_ALIGN_CHECK_EN (misaligned-target exception).
package jbr_unit_pkg;

  localparam int unsigned REG_W     = 32;
  localparam int unsigned JBR_BUS_W = REG_W + 1;
  localparam int unsigned BR_OP_W   = 4;

  typedef enum logic [BR_OP_W-1:0] {
    BR_OP_NONE = 4'd0,
    BR_OP_BEQ  = 4'd1,
    BR_OP_BNE  = 4'd2,
    BR_OP_BLT  = 4'd3,
    BR_OP_BGE  = 4'd4,
    BR_OP_BLTU = 4'd5,
    BR_OP_BGEU = 4'd6,
    BR_OP_B    = 4'd7,
    BR_OP_BL   = 4'd8,
    BR_OP_JIRL = 4'd9
  } br_op_e;

  typedef enum logic [1:0] {
    JBR_ST_IDLE     = 2'd0,
    JBR_ST_REDIRECT = 2'd1,
    JBR_ST_DONE     = 2'd2
  } jbr_state_e;

  // BL and JIRL write pc+4 to the link register.
  function automatic logic is_link_op(input logic [BR_OP_W-1:0] op);
    return (op == BR_OP_BL) || (op == BR_OP_JIRL);
  endfunction

endpackage

// File: rtl/jbr_cond.sv
// Combinational branch condition, target and link evaluation.
// No configuration macros; alignment checking lives in jbr_unit (JBR_ALIGN_CHECK_EN).
module jbr_cond
  import jbr_unit_pkg::*;
#(
  parameter int unsigned RegW = REG_W
) (
  input  logic [BR_OP_W-1:0] op,
  input  logic [RegW-1:0]    pc,
  input  logic [RegW-1:0]    src1,
  input  logic [RegW-1:0]    src2,
  input  logic [RegW-1:0]    offs,
  output logic               cond,
  output logic [RegW-1:0]    target,
  output logic [RegW-1:0]    link
);

  always_comb begin
    cond = 1'b0;
    case (op)
      BR_OP_BEQ:  cond = (src1 == src2);
      BR_OP_BNE:  cond = (src1 != src2);
      BR_OP_BLT:  cond = ($signed(src1) <  $signed(src2));
      BR_OP_BGE:  cond = ($signed(src1) >= $signed(src2));
      BR_OP_BLTU: cond = (src1 <  src2);
      BR_OP_BGEU: cond = (src1 >= src2);
      BR_OP_B,
      BR_OP_BL,
      BR_OP_JIRL: cond = 1'b1;
      default:    cond = 1'b0;
    endcase
  end

  // JIRL is register-relative; every other branch is PC-relative.
  assign target = ((op == BR_OP_JIRL) ? src1 : pc) + offs;
  assign link   = is_link_op(op) ? (pc + RegW'(4)) : '0;

endmodule

// File: rtl/jbr_unit.sv
// EX-stage branch resolution: holds a redirect on the jump/branch bus until fetch accepts it.
// Define JBR_ALIGN_CHECK_EN to suppress misaligned redirects and raise ex_adef_o instead.
module jbr_unit
  import jbr_unit_pkg::*;
#(
  parameter int unsigned RegW = REG_W
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            id_to_ex_valid_i,
  output logic            ex_allow_in_o,
  input  logic [3:0]      id_br_op_i,
  input  logic [RegW-1:0] id_pc_i,
  input  logic [RegW-1:0] id_src1_i,
  input  logic [RegW-1:0] id_src2_i,
  input  logic [RegW-1:0] id_offs_i,
  input  logic            if_allow_nxt_pc_i,
  output logic [RegW:0]   jbr_bus_o,
  output logic            ex_cancel_o,
  output logic            ex_to_mem_valid_o,
  input  logic            mem_allow_in_i,
  output logic [RegW-1:0] ex_pc_o,
  output logic [RegW-1:0] ex_link_o,
  output logic            ex_adef_o
);

  logic               ex_valid_q;
  logic [BR_OP_W-1:0] op_q;
  logic [RegW-1:0]    pc_q, src1_q, src2_q, offs_q;
  logic [RegW-1:0]    target_q, target_d;
  jbr_state_e         state_q, state_d;

  logic            cond, misalign, taken_raw, bus_taken;
  logic            accept, ready_go, leave, load;
  logic [RegW-1:0] target, link, bus_target;

  jbr_cond #(.RegW(RegW)) u_cond (
    .op     (op_q),
    .pc     (pc_q),
    .src1   (src1_q),
    .src2   (src2_q),
    .offs   (offs_q),
    .cond   (cond),
    .target (target),
    .link   (link)
  );

`ifdef JBR_ALIGN_CHECK_EN
  assign misalign  = cond & (target[1:0] != 2'b00);
  assign ex_adef_o = ex_valid_q & misalign;
`else
  assign misalign  = 1'b0;
  assign ex_adef_o = 1'b0;
`endif

  // Handshake: a pending redirect blocks the instruction from leaving EX.
  assign taken_raw   = ex_valid_q & cond & ~misalign & (state_q == JBR_ST_IDLE);
  assign bus_taken   = taken_raw | (state_q == JBR_ST_REDIRECT);
  assign accept      = bus_taken & if_allow_nxt_pc_i;
  assign ready_go    = ~(bus_taken & ~if_allow_nxt_pc_i);
  assign leave       = ex_to_mem_valid_o & mem_allow_in_i;
  assign load        = ex_allow_in_o & id_to_ex_valid_i & ~accept;

  assign ex_to_mem_valid_o = ex_valid_q & ready_go;
  assign ex_allow_in_o     = ~ex_valid_q | (ready_go & mem_allow_in_i);
  assign ex_cancel_o       = accept;

  assign bus_target = (state_q == JBR_ST_REDIRECT) ? target_q :
                      taken_raw                    ? target   : '0;
  assign jbr_bus_o  = {bus_taken, bus_target};

  assign ex_pc_o   = pc_q;
  assign ex_link_o = ex_valid_q ? link : '0;

  // Stage register; the wrong-path instruction offered during a cancel is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_q <= 1'b0;
      op_q       <= '0;
      pc_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      offs_q     <= '0;
    end else begin
      if (ex_allow_in_o) ex_valid_q <= load;
      if (load) begin
        op_q   <= id_br_op_i;
        pc_q   <= id_pc_i;
        src1_q <= id_src1_i;
        src2_q <= id_src2_i;
        offs_q <= id_offs_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= JBR_ST_IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Redirect FSM: one bus run and one cancel per taken branch.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      JBR_ST_IDLE: begin
        if (taken_raw & ~accept) begin
          state_d  = JBR_ST_REDIRECT;
          target_d = target;
        end else if (accept & ~leave) begin
          state_d = JBR_ST_DONE;
        end
      end
      JBR_ST_REDIRECT: begin
        if (accept) state_d = leave ? JBR_ST_IDLE : JBR_ST_DONE;
      end
      JBR_ST_DONE: begin
        if (leave) state_d = JBR_ST_IDLE;
      end
      default: state_d = JBR_ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jbr_unit.sv
// Scoreboard bench for jbr_unit: directed scenarios plus randomized traffic vs. a reference model.
// Honours JBR_ALIGN_CHECK_EN when the design is built with it.
module tb_jbr_unit;

  localparam int unsigned W = 32;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         id_to_ex_valid_i = 1'b0;
  logic         ex_allow_in_o;
  logic [3:0]   id_br_op_i = '0;
  logic [W-1:0] id_pc_i = '0, id_src1_i = '0, id_src2_i = '0, id_offs_i = '0;
  logic         if_allow_nxt_pc_i = 1'b1;
  logic [W:0]   jbr_bus_o;
  logic         ex_cancel_o;
  logic         ex_to_mem_valid_o;
  logic         mem_allow_in_i = 1'b1;
  logic [W-1:0] ex_pc_o, ex_link_o;
  logic         ex_adef_o;

  jbr_unit dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .id_to_ex_valid_i  (id_to_ex_valid_i),
    .ex_allow_in_o     (ex_allow_in_o),
    .id_br_op_i        (id_br_op_i),
    .id_pc_i           (id_pc_i),
    .id_src1_i         (id_src1_i),
    .id_src2_i         (id_src2_i),
    .id_offs_i         (id_offs_i),
    .if_allow_nxt_pc_i (if_allow_nxt_pc_i),
    .jbr_bus_o         (jbr_bus_o),
    .ex_cancel_o       (ex_cancel_o),
    .ex_to_mem_valid_o (ex_to_mem_valid_o),
    .mem_allow_in_i    (mem_allow_in_i),
    .ex_pc_o           (ex_pc_o),
    .ex_link_o         (ex_link_o),
    .ex_adef_o         (ex_adef_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         taken;
    logic [W-1:0] target;
    logic [W-1:0] pc;
    logic [W-1:0] link;
    logic         adef;
    logic         redirected;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_dropped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural meaning of each opcode in plain arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] pc,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] offs);
    exp_t e;
    logic c;
    longint unsigned base, sum;
    e = '0;
    case (op)
      4'd1:          c = (a == b);
      4'd2:          c = (a != b);
      4'd3:          c = (int'(a) <  int'(b));
      4'd4:          c = (int'(a) >= int'(b));
      4'd5:          c = (longint'({32'd0, a}) <  longint'({32'd0, b}));
      4'd6:          c = (longint'({32'd0, a}) >= longint'({32'd0, b}));
      4'd7, 4'd8, 4'd9: c = 1'b1;
      default:       c = 1'b0;
    endcase
    base = (op == 4'd9) ? longint'({32'd0, a}) : longint'({32'd0, pc});
    sum  = (base + longint'({32'd0, offs})) % 64'h1_0000_0000;
    e.pc   = pc;
    e.link = (op == 4'd8 || op == 4'd9) ? W'(longint'({32'd0, pc}) + 4) : '0;
    e.taken = c;
    if (c) e.target = W'(sum);
`ifdef JBR_ALIGN_CHECK_EN
    if (c && e.target[1:0] != 2'b00) begin
      e.taken  = 1'b0;
      e.target = '0;
      e.adef   = 1'b1;
    end
`endif
    return e;
  endfunction

  // Monitor: compares the EX instruction at the head of the queue against DUT outputs.
  exp_t f;
  logic qv, exp_tk;
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      qv     = (exp_q.size() != 0);
      f      = qv ? exp_q[0] : '0;
      exp_tk = qv && f.taken && !f.redirected;
      chk("bus_taken", 64'(jbr_bus_o[W]), 64'(exp_tk));
      chk("bus_target", 64'(jbr_bus_o[W-1:0]), exp_tk ? 64'(f.target) : 64'd0);
      chk("cancel", 64'(ex_cancel_o), 64'(exp_tk && if_allow_nxt_pc_i));
      chk("to_mem_valid", 64'(ex_to_mem_valid_o), 64'(qv && !(exp_tk && !if_allow_nxt_pc_i)));
      chk("allow_in", 64'(ex_allow_in_o),
          64'(!qv || (!(exp_tk && !if_allow_nxt_pc_i) && mem_allow_in_i)));
      if (qv) chk("adef", 64'(ex_adef_o), 64'(f.adef));
      if (ex_cancel_o && qv) exp_q[0].redirected = 1'b1;
      if (ex_to_mem_valid_o && mem_allow_in_i) begin
        if (!qv) begin
          n_checks++;
          n_errors++;
          $display("FAIL retire_unexpected: got pc %0h expected no instruction", ex_pc_o);
        end else begin
          f = exp_q.pop_front();
          chk("retire_pc", 64'(ex_pc_o), 64'(f.pc));
          chk("retire_link", 64'(ex_link_o), 64'(f.link));
        end
      end
    end
  end

  task automatic offer(input logic [3:0] op, input logic [W-1:0] pc, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] o);
    id_br_op_i = op; id_pc_i = pc; id_src1_i = a; id_src2_i = b; id_offs_i = o;
    id_to_ex_valid_i = 1'b1;
  endtask

  // Called at a negedge: resolve the ID handshake, then step to just past the next posedge.
  task automatic fin();
    logic consumed, push_it;
    exp_t e;
    consumed = 1'b0;
    push_it  = 1'b0;
    e        = '0;
    if (id_to_ex_valid_i && rst_n_i) begin
      if (ex_cancel_o) begin
        consumed = 1'b1;
        n_dropped++;
      end else if (ex_allow_in_o) begin
        consumed = 1'b1;
        push_it  = 1'b1;
        e = model(id_br_op_i, id_pc_i, id_src1_i, id_src2_i, id_offs_i);
      end
    end
    @(posedge clk_i); #1;
    if (consumed) id_to_ex_valid_i = 1'b0;
    if (push_it) exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk_i);
    fin();
  endtask

  task automatic rand_offer();
    logic [3:0]   op;
    logic [W-1:0] a, b, o, r;
    op = 4'($urandom_range(0, 15));
    a  = $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a ^ 32'h8000_0000;
      default: b = $urandom;
    endcase
    r = $urandom;
    o = {{14{r[17]}}, r[17:0]};
    if ($urandom_range(0, 3) != 0) o = o & 32'hFFFF_FFFC;
    if ($urandom_range(0, 1) != 0) a = a & 32'hFFFF_FFFC;
    offer(op, $urandom & 32'hFFFF_FFFC, a, b, o);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_allow_in", 64'(ex_allow_in_o), 64'd1);
    chk("rst_bus", 64'(jbr_bus_o), 64'd0);
    chk("rst_cancel", 64'(ex_cancel_o), 64'd0);
    chk("rst_to_mem", 64'(ex_to_mem_valid_o), 64'd0);
    chk("rst_pc_link", {ex_pc_o, ex_link_o}, 64'd0);
    @(negedge clk_i); #1 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // BEQ taken, accepted at once; the ID instruction in the cancel cycle is dropped
    offer(4'd1, 32'h1c000100, 32'd5, 32'd5, 32'h40);
    cyc();
    offer(4'd0, 32'h1c000104, 32'd0, 32'd0, 32'd0);
    @(negedge clk_i);
    chk("beq_bus", 64'(jbr_bus_o), {31'd0, 1'b1, 32'h1c000140});
    chk("beq_cancel", 64'(ex_cancel_o), 64'd1);
    fin();
    @(negedge clk_i);
    chk("beq_after_bus", 64'(jbr_bus_o), 64'd0);
    chk("beq_dropped", 64'(ex_to_mem_valid_o), 64'd0);
    fin();

    // BNE not taken passes straight through
    offer(4'd2, 32'h1c000300, 32'd7, 32'd7, 32'h20);
    cyc();
    @(negedge clk_i);
    chk("bne_bus", 64'(jbr_bus_o), 64'd0);
    chk("bne_to_mem", 64'(ex_to_mem_valid_o), 64'd1);
    fin();

    // Signed vs unsigned compare of the same operands
    offer(4'd3, 32'h1c000400, 32'hFFFF_FFFF, 32'd1, 32'h10);
    cyc();
    @(negedge clk_i);
    chk("blt_taken", 64'(jbr_bus_o[W]), 64'd1);
    fin();
    offer(4'd5, 32'h1c000400, 32'hFFFF_FFFF, 32'd1, 32'h10);
    cyc();
    @(negedge clk_i);
    chk("bltu_taken", 64'(jbr_bus_o[W]), 64'd0);
    fin();

    // JIRL held on the bus while fetch stalls
    if_allow_nxt_pc_i = 1'b0;
    offer(4'd9, 32'h1c000200, 32'h1c001000, 32'd0, 32'd8);
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("jirl_hold_bus", 64'(jbr_bus_o), {31'd0, 1'b1, 32'h1c001008});
      chk("jirl_hold_allow", 64'(ex_allow_in_o), 64'd0);
      fin();
    end
    if_allow_nxt_pc_i = 1'b1;
    @(negedge clk_i);
    chk("jirl_cancel", 64'(ex_cancel_o), 64'd1);
    chk("jirl_bus", 64'(jbr_bus_o), {31'd0, 1'b1, 32'h1c001008});
    chk("jirl_link", 64'(ex_link_o), 64'h1c000204);
    fin();

    // BL accepted while MEM stalls: no second assertion or cancel
    mem_allow_in_i = 1'b0;
    offer(4'd8, 32'h1c000500, 32'd0, 32'd0, 32'h100);
    cyc();
    @(negedge clk_i);
    chk("bl_cancel", 64'(ex_cancel_o), 64'd1);
    fin();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bl_done_bus", 64'(jbr_bus_o), 64'd0);
      chk("bl_done_cancel", 64'(ex_cancel_o), 64'd0);
      fin();
    end
    mem_allow_in_i = 1'b1;
    @(negedge clk_i);
    chk("bl_leave", 64'(ex_to_mem_valid_o), 64'd1);
    chk("bl_link", 64'(ex_link_o), 64'h1c000504);
    fin();

    // Misaligned JIRL target
    offer(4'd9, 32'h1c000200, 32'h1c001000, 32'd0, 32'd2);
    cyc();
    @(negedge clk_i);
`ifdef JBR_ALIGN_CHECK_EN
    chk("misalign_bus", 64'(jbr_bus_o[W]), 64'd0);
    chk("misalign_adef", 64'(ex_adef_o), 64'd1);
`else
    chk("misalign_bus", 64'(jbr_bus_o), {31'd0, 1'b1, 32'h1c001002});
    chk("misalign_adef", 64'(ex_adef_o), 64'd0);
`endif
    fin();

    // Randomized traffic with random fetch/MEM back-pressure
    for (int i = 0; i < 3000; i++) begin
      if_allow_nxt_pc_i = ($urandom_range(0, 9) < 7);
      mem_allow_in_i    = ($urandom_range(0, 9) < 7);
      if (!id_to_ex_valid_i && $urandom_range(0, 9) < 6) rand_offer();
      cyc();
    end
    id_to_ex_valid_i  = 1'b0;
    if_allow_nxt_pc_i = 1'b1;
    mem_allow_in_i    = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while a redirect is pending
    if_allow_nxt_pc_i = 1'b0;
    offer(4'd9, 32'h1c000200, 32'h1c001000, 32'd0, 32'd8);
    cyc();
    cyc();
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_bus", 64'(jbr_bus_o), 64'd0);
    chk("arst_cancel", 64'(ex_cancel_o), 64'd0);
    chk("arst_to_mem", 64'(ex_to_mem_valid_o), 64'd0);
    chk("arst_allow_in", 64'(ex_allow_in_o), 64'd1);
    chk("arst_pc_link", {ex_pc_o, ex_link_o}, 64'd0);
    exp_q.delete();
    id_to_ex_valid_i = 1'b0;
    @(negedge clk_i); #1 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("arst_idle_bus", 64'(jbr_bus_o), 64'd0);
    fin();
    if_allow_nxt_pc_i = 1'b1;
    offer(4'd0, 32'h1c000600, 32'd0, 32'd0, 32'd0);
    cyc();
    @(negedge clk_i);
    chk("post_rst_pc", 64'(ex_pc_o), 64'h1c000600);
    fin();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
